// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 register map and sequencer constants
package max7219_pkg;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int INIT_STEPS = 5;
  localparam int ROWS       = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ROWS = 1'b1
  } seq_state_t;

endpackage

// File: rtl/max7219_init_rom.sv
// rtl/max7219_init_rom.sv - init step to MAX7219 address/data byte pair
module max7219_init_rom
  import max7219_pkg::*;
(
  input  logic [2:0] step,
  input  logic [3:0] intensity,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data
);

  always_comb begin
    reg_addr = REG_NOOP;
    reg_data = 8'h00;
    case (step)
      3'd0: reg_addr = REG_TEST;
      3'd1: reg_addr = REG_DECODE;
      3'd2: begin
        reg_addr = REG_SCANLIMIT;
        reg_data = 8'h07;
      end
      3'd3: begin
        reg_addr = REG_INTENSITY;
        reg_data = {4'h0, intensity};
      end
      3'd4: begin
        reg_addr = REG_SHUTDOWN;
        reg_data = 8'h01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/max7219_frame_sequencer.sv
// rtl/max7219_frame_sequencer.sv - init then endless row refresh feeding the MAX7219 shifter
module max7219_frame_sequencer
  import max7219_pkg::*;
#(
  parameter int SIZE = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_finished,
  input  logic [64*SIZE-1:0]  frame,
  input  logic [3:0]          intensity,
  input  logic                reinit,
  output logic [8*SIZE-1:0]   address,
  output logic [8*SIZE-1:0]   data,
  output logic                init_done,
  output logic                frame_done,
  output logic [2:0]          row_idx
);

  seq_state_t          state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [2:0]          row_q, row_d;
  logic [64*SIZE-1:0]  shadow_q, shadow_d;
  logic                fin_q;
  logic                pend_q, pend_d;
  logic [8*SIZE-1:0]   address_d, data_d;
  logic                init_done_d, frame_done_d;
  logic                adv, reinit_req;
  logic [2:0]          rom_step, next_row;
  logic [7:0]          rom_addr, rom_data, next_row_addr;

  // Gather row r of every device slot into one shifter data word.
  function automatic logic [8*SIZE-1:0] row_word(input logic [64*SIZE-1:0] src,
                                                 input logic [2:0] r);
    row_word = '0;
    for (int d = 0; d < SIZE; d++) begin
      row_word[8*d +: 8] = src[64*d + 8*int'(r) +: 8];
    end
  endfunction

  assign adv           = spi_finished & ~fin_q;
  assign reinit_req    = reinit | pend_q;
  assign rom_step      = (reinit_req || state_q == ST_ROWS) ? 3'd0 : step_q + 3'd1;
  assign next_row      = row_q + 3'd1;
  assign next_row_addr = REG_DIGIT0 + {5'd0, next_row};

  max7219_init_rom u_init_rom (
    .step      (rom_step),
    .intensity (intensity),
    .reg_addr  (rom_addr),
    .reg_data  (rom_data)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    row_d        = row_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q | reinit;
    address_d    = address;
    data_d       = data;
    init_done_d  = init_done;
    frame_done_d = 1'b0;
    if (adv) begin
      pend_d = 1'b0;
      if (reinit_req) begin
        state_d     = ST_INIT;
        step_d      = 3'd0;
        row_d       = 3'd0;
        init_done_d = 1'b0;
        address_d   = {SIZE{rom_addr}};
        data_d      = {SIZE{rom_data}};
      end else if (state_q == ST_INIT) begin
        if (step_q < 3'(INIT_STEPS - 1)) begin
          step_d    = step_q + 3'd1;
          address_d = {SIZE{rom_addr}};
          data_d    = {SIZE{rom_data}};
        end else begin
          // Row 0 bypasses the shadow so it matches the frame captured this edge.
          state_d     = ST_ROWS;
          step_d      = 3'd0;
          row_d       = 3'd0;
          shadow_d    = frame;
          init_done_d = 1'b1;
          address_d   = {SIZE{REG_DIGIT0}};
          data_d      = row_word(frame, 3'd0);
        end
      end else begin
        if (row_q < 3'(ROWS - 1)) begin
          row_d     = next_row;
          address_d = {SIZE{next_row_addr}};
          data_d    = row_word(shadow_q, next_row);
        end else begin
          row_d        = 3'd0;
          frame_done_d = 1'b1;
          shadow_d     = frame;
          address_d    = {SIZE{REG_DIGIT0}};
          data_d       = row_word(frame, 3'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      step_q     <= 3'd0;
      row_q      <= 3'd0;
      shadow_q   <= '0;
      fin_q      <= 1'b0;
      pend_q     <= 1'b0;
      address    <= {SIZE{REG_TEST}};
      data       <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      row_q      <= row_d;
      shadow_q   <= shadow_d;
      fin_q      <= spi_finished;
      pend_q     <= pend_d;
      address    <= address_d;
      data       <= data_d;
      init_done  <= init_done_d;
      frame_done <= frame_done_d;
    end
  end

  assign row_idx = row_q;

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// tb/tb_max7219_frame_sequencer.sv - directed self-checking bench for max7219_frame_sequencer
module tb_max7219_frame_sequencer;

  localparam int SIZE = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               spi_finished;
  logic [64*SIZE-1:0] frame;
  logic [3:0]         intensity;
  logic               reinit;
  logic [8*SIZE-1:0]  address;
  logic [8*SIZE-1:0]  data;
  logic               init_done;
  logic               frame_done;
  logic [2:0]         row_idx;

  int compared = 0;
  int mismatched = 0;
  int fd_count = 0;
  logic [15:0] fd_addr = 16'h0;
  logic [15:0] fd_data = 16'h0;

  always #5 clk = ~clk;

  max7219_frame_sequencer #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_finished (spi_finished),
    .frame        (frame),
    .intensity    (intensity),
    .reinit       (reinit),
    .address      (address),
    .data         (data),
    .init_done    (init_done),
    .frame_done   (frame_done),
    .row_idx      (row_idx)
  );

  always @(negedge clk) begin
    if (frame_done) begin
      fd_count = fd_count + 1;
      fd_addr  = address;
      fd_data  = data;
    end
  end

  // Slot d row r = {base+d, r}.
  function automatic logic [127:0] mk_frame(input logic [3:0] base);
    logic [127:0] f;
    f = '0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 8; r++)
        f[64*d + 8*r +: 8] = {base + 4'(d), 4'(r)};
    return f;
  endfunction

  task automatic advance(input int hold);
    @(negedge clk);
    spi_finished = 1'b1;
    repeat (hold) @(negedge clk);
    spi_finished = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; spi_finished = 1'b0; reinit = 1'b0;
    intensity = 4'h5; frame = mk_frame(4'h0);
    repeat (3) @(negedge clk);
    compared++; if (address !== 16'h0F0F) begin mismatched++; $display("FAIL reset_address got %h want 0f0f", address); end
    compared++; if (data !== 16'h0000) begin mismatched++; $display("FAIL reset_data got %h want 0000", data); end
    compared++; if (init_done !== 1'b0) begin mismatched++; $display("FAIL reset_init_done got %b want 0", init_done); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    compared++; if (row_idx !== 3'd0) begin mismatched++; $display("FAIL reset_row_idx got %0d want 0", row_idx); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (address !== 16'h0F0F || data !== 16'h0000) begin mismatched++; $display("FAIL step0_after_release got %h/%h want 0f0f/0000", address, data); end
  endtask

  task automatic test_init;
    logic [15:0] ea [5];
    logic [15:0] ed [5];
    ea = '{16'h0F0F, 16'h0909, 16'h0B0B, 16'h0A0A, 16'h0C0C};
    ed = '{16'h0000, 16'h0000, 16'h0707, 16'h0505, 16'h0101};
    for (int i = 1; i < 5; i++) begin
      advance(1);
      compared++; if (address !== ea[i]) begin mismatched++; $display("FAIL init_addr step %0d got %h want %h", i, address, ea[i]); end
      compared++; if (data !== ed[i]) begin mismatched++; $display("FAIL init_data step %0d got %h want %h", i, data, ed[i]); end
      compared++; if (init_done !== 1'b0) begin mismatched++; $display("FAIL init_done_low step %0d got %b want 0", i, init_done); end
      if (i == 3) begin
        intensity = 4'h9;
        repeat (4) @(negedge clk);
        compared++; if (data !== 16'h0505) begin mismatched++; $display("FAIL intensity_held got %h want 0505", data); end
      end
    end
  endtask

  task automatic test_rows;
    int fd0;
    logic [7:0] a;
    fd0 = fd_count;
    advance(1);
    compared++; if (address !== 16'h0101 || data !== 16'h1000) begin mismatched++; $display("FAIL row0_first got %h/%h want 0101/1000", address, data); end
    compared++; if (init_done !== 1'b1) begin mismatched++; $display("FAIL init_done_high got %b want 1", init_done); end
    compared++; if (fd_count !== fd0) begin mismatched++; $display("FAIL no_fd_from_init got %0d want %0d", fd_count, fd0); end
    for (int r = 1; r < 8; r++) begin
      advance(1);
      a = 8'(r + 1);
      compared++; if (address !== {a, a}) begin mismatched++; $display("FAIL row_addr r%0d got %h want %h", r, address, {a, a}); end
      compared++; if (data !== {4'h1, 4'(r), 4'h0, 4'(r)}) begin mismatched++; $display("FAIL row_data r%0d got %h want %h", r, data, {4'h1, 4'(r), 4'h0, 4'(r)}); end
      compared++; if (row_idx !== 3'(r)) begin mismatched++; $display("FAIL row_idx r%0d got %0d want %0d", r, row_idx, r); end
    end
    advance(1);
    compared++; if (row_idx !== 3'd0 || address !== 16'h0101) begin mismatched++; $display("FAIL wrap_row0 got %0d/%h want 0/0101", row_idx, address); end
    compared++; if (fd_count !== fd0 + 1) begin mismatched++; $display("FAIL frame_done_count got %0d want %0d", fd_count, fd0 + 1); end
    compared++; if (fd_addr !== 16'h0101 || fd_data !== 16'h1000) begin mismatched++; $display("FAIL frame_done_with_row0 got %h/%h want 0101/1000", fd_addr, fd_data); end
  endtask

  task automatic test_tearing;
    repeat (3) advance(1);
    compared++; if (row_idx !== 3'd3) begin mismatched++; $display("FAIL tear_at_row3 got %0d want 3", row_idx); end
    frame = mk_frame(4'hA);
    repeat (3) @(negedge clk);
    compared++; if (data !== 16'h1303) begin mismatched++; $display("FAIL tear_row3_held got %h want 1303", data); end
    for (int r = 4; r < 8; r++) begin
      advance(1);
      compared++; if (data !== {4'h1, 4'(r), 4'h0, 4'(r)}) begin mismatched++; $display("FAIL tear_old r%0d got %h want %h", r, data, {4'h1, 4'(r), 4'h0, 4'(r)}); end
    end
    advance(1);
    compared++; if (data !== 16'hB0A0) begin mismatched++; $display("FAIL tear_new_row0 got %h want b0a0", data); end
    advance(1);
    compared++; if (data !== 16'hB1A1 || address !== 16'h0202) begin mismatched++; $display("FAIL tear_new_row1 got %h/%h want 0202/b1a1", address, data); end
  endtask

  task automatic test_held;
    @(negedge clk);
    spi_finished = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compared++; if (row_idx !== 3'd2 || address !== 16'h0303 || data !== 16'hB2A2) begin mismatched++; $display("FAIL held_cycle %0d got %0d/%h/%h want 2/0303/b2a2", c, row_idx, address, data); end
    end
    spi_finished = 1'b0;
    @(negedge clk);
    advance(1);
    compared++; if (row_idx !== 3'd3 || data !== 16'hB3A3) begin mismatched++; $display("FAIL held_next got %0d/%h want 3/b3a3", row_idx, data); end
  endtask

  task automatic test_reinit;
    repeat (2) advance(1);
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (address !== 16'h0606 || init_done !== 1'b1) begin mismatched++; $display("FAIL reinit_pending_hold got %h/%b want 0606/1", address, init_done); end
    advance(1);
    compared++; if (address !== 16'h0F0F || data !== 16'h0000) begin mismatched++; $display("FAIL reinit_word got %h/%h want 0f0f/0000", address, data); end
    compared++; if (init_done !== 1'b0 || row_idx !== 3'd0) begin mismatched++; $display("FAIL reinit_init_done got %b/%0d want 0/0", init_done, row_idx); end
    advance(1);
    compared++; if (address !== 16'h0909) begin mismatched++; $display("FAIL reinit_no_extra got %h want 0909", address); end
    advance(1);
    advance(1);
    compared++; if (address !== 16'h0A0A || data !== 16'h0909) begin mismatched++; $display("FAIL reinit_intensity got %h/%h want 0a0a/0909", address, data); end
    advance(1);
    advance(1);
    compared++; if (init_done !== 1'b1 || data !== 16'hB0A0) begin mismatched++; $display("FAIL reinit_back_rows got %b/%h want 1/b0a0", init_done, data); end
    @(negedge clk);
    spi_finished = 1'b1;
    reinit = 1'b1;
    @(negedge clk);
    spi_finished = 1'b0;
    reinit = 1'b0;
    @(negedge clk);
    compared++; if (address !== 16'h0F0F || data !== 16'h0000 || init_done !== 1'b0) begin mismatched++; $display("FAIL collision_word got %h/%h/%b want 0f0f/0000/0", address, data, init_done); end
    advance(1);
    compared++; if (address !== 16'h0909) begin mismatched++; $display("FAIL collision_no_extra got %h want 0909", address); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] ea [5];
    logic [15:0] ed [5];
    ea = '{16'h0F0F, 16'h0909, 16'h0B0B, 16'h0A0A, 16'h0C0C};
    ed = '{16'h0000, 16'h0000, 16'h0707, 16'h0909, 16'h0101};
    repeat (8) advance(1);
    compared++; if (row_idx !== 3'd4 || address !== 16'h0505) begin mismatched++; $display("FAIL pre_reset_row4 got %0d/%h want 4/0505", row_idx, address); end
    #2;
    reset_n = 1'b0;
    #1;
    compared++; if (address !== 16'h0F0F || data !== 16'h0000) begin mismatched++; $display("FAIL async_reset_word got %h/%h want 0f0f/0000", address, data); end
    compared++; if (init_done !== 1'b0 || row_idx !== 3'd0) begin mismatched++; $display("FAIL async_reset_flags got %b/%0d want 0/0", init_done, row_idx); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (address !== 16'h0F0F) begin mismatched++; $display("FAIL replay_step0 got %h want 0f0f", address); end
    for (int i = 1; i < 5; i++) begin
      advance(1);
      compared++; if (address !== ea[i] || data !== ed[i]) begin mismatched++; $display("FAIL replay step %0d got %h/%h want %h/%h", i, address, data, ea[i], ed[i]); end
    end
    advance(1);
    compared++; if (init_done !== 1'b1 || address !== 16'h0101 || data !== 16'hB0A0) begin mismatched++; $display("FAIL replay_row0 got %b/%h/%h want 1/0101/b0a0", init_done, address, data); end
  endtask

  initial begin
    test_reset;
    test_init;
    test_rows;
    test_tearing;
    test_held;
    test_reinit;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/max7219_frame_sequencer.md
# max7219_frame_sequencer

Command sequencer directly upstream of the MAX7219 SPI shifter. It drives the shifter's per-device `address`/`data` words and advances one command each time the shifter reports a completed transfer on `finished`. After reset it issues the five-command MAX7219 init sequence, then refreshes rows 1–8 of a chain of `SIZE` 8x8 matrices without end. The frame is taken from a shadow copy so that no pass ever mixes two frames.

## Interface
- `SIZE`, 2, number of daisy-chained MAX7219 devices; must equal the shifter's `SIZE`.
- `clk`  in  1  system clock, shared with the shifter.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_finished`  in  1  shifter `finished`; high for at least 1 cycle at the end of each transfer.
- `frame`  in  64*SIZE  pixels; `frame[64*d + 8*r +: 8]` is row r (0..7) of device slot d.
- `intensity`  in  4  brightness code; sampled when the intensity command is loaded.
- `reinit`  in  1  single-cycle request to rerun the init sequence.
- `address`  out  8*SIZE  to shifter `address`; slot d is `[8*d +: 8]`.
- `data`  out  8*SIZE  to shifter `data`; slot d is `[8*d +: 8]`.
- `init_done`  out  1  high while row refresh is running.
- `frame_done`  out  1  one-cycle pulse when a full 8-row pass completes.
- `row_idx`  out  3  row currently presented (0..7); 0 during init.

## Operation
- Slot SIZE-1 is shifted first, so it lands in the device farthest from DIN. Slot 0 is the device nearest DIN.
- Every slot receives the same address. During init every slot also receives the same data.
- Init steps (address, data):
  - 0: 0x0F, 0x00 (display test off)
  - 1: 0x09, 0x00 (no decode)
  - 2: 0x0B, 0x07 (scan all 8 digits)
  - 3: 0x0A, {4'h0, intensity}
  - 4: 0x0C, 0x01 (normal operation)
- Row steps r = 0..7: address = r+1 in every slot. Slot d data = `shadow[64*d + 8*r +: 8]`.
- FSM has two states: INIT (step counter 0..4) and ROWS (row counter 0..7).
- Advance event: `spi_finished` is 1 now and was 0 in the previous cycle (rising edge from a registered copy).
- Transitions on an advance event:
  - INIT step s<4 → step s+1.
  - INIT step 4 → ROWS row 0; capture `shadow <= frame`; `init_done` goes to 1.
  - ROWS r<7 → r+1.
  - ROWS 7 → row 0; pulse `frame_done`; capture `shadow <= frame`.
- Whenever the sequencer enters row 0, row 0 data comes from `frame` directly (not from the old shadow) in the same edge the shadow is captured.
- `reinit` sets a pending flag. On the next advance event the FSM goes to INIT step 0, clears the flag, and drops `init_done`.
- If `reinit` arrives in the same cycle as an advance event, reinit wins: the FSM goes to step 0 and no flag is left pending.
- `reinit` during INIT restarts the sequence at step 0.
- Between advance events, `address`, `data`, `row_idx` and `init_done` are held constant, even if `frame` or `intensity` change.

## Timing
- Reset values:
  - state INIT, step 0
  - `address` = {SIZE{8'h0F}}, `data` = 0
  - `init_done` = 0, `frame_done` = 0, `row_idx` = 0
  - `shadow` = 0, edge register = 0, reinit flag = 0
- Step 0 is valid out of reset because the shifter loads immediately after leaving IDLE.
- All outputs are registered. New values appear in the cycle after the `spi_finished` rising edge.
- The shifter loads 2 cycles after its last SEND cycle, so the new word is stable at least 1 cycle before the load.
- An advance event is one cycle only. A `spi_finished` held high for N cycles advances exactly once.
- Sequence length: 5 transfers of init, then 8 transfers per frame.
- `frame_done` is high in the same cycle that row 0 first appears.
- Reset asserted mid-sequence returns every register to its reset value asynchronously. Init restarts from step 0.

## Structure
- Shared package `max7219_pkg` holds:
  - register addresses `REG_NOOP`=0x00, `REG_DIGIT0`=0x01, `REG_DECODE`=0x09, `REG_INTENSITY`=0x0A, `REG_SCANLIMIT`=0x0B, `REG_SHUTDOWN`=0x0C, `REG_TEST`=0x0F
  - `INIT_STEPS`=5
  - `ROWS`=8
- Sub-module `max7219_init_rom`: combinational map from step (3 bits) and `intensity` to one address/data byte pair, replicated per slot by the sequencer.
- The top level holds the FSM, counters, edge detector, reinit flag and frame shadow. Expect roughly 150–250 lines of RTL in total.

## Test plan
- **Reset and init:** release reset with SIZE=2, intensity=4'h5, pulse `spi_finished` 1 cycle every 40 cycles.
  - Required `address`/`data` pairs in order: 0F0F/0000, 0909/0000, 0B0B/0707, 0A0A/0505, 0C0C/0101.
  - Then row 0 appears and `init_done`=1.
- **Row refresh:** frame with row r of slot d = {d[3:0], r[3:0]}, e.g. slot 1 row 2 = 0x12.
  - Rows present address 0101..0808.
  - Row 2 data = 0x1202.
  - `frame_done` pulses once per 8 advances.
- **Tearing:** change `frame` while row 3 is presented.
  - Rows 3–7 still show the old frame.
  - Row 0 of the next pass shows the new frame.
- **Held finished:** hold `spi_finished` high for 5 cycles.
  - Exactly one advance.
  - Outputs stable during the remaining 4 cycles.
- **Reinit collision:** assert `reinit` during row 5, and again in the same cycle as an advance edge.
  - Each time the next word is 0F0F/0000 and `init_done` drops to 0.
  - No extra restart follows.
- **Reset mid-sequence:** assert `reset_n`=0 during row 4.
  - Outputs return to reset values immediately.
  - Init replays completely after release.
